// File: rtl/secp256k1_mult_arb.sv
// rtl/secp256k1_mult_arb.sv - round-robin sharing of one secp256k1 modular multiplier
// Requests are tagged with the client index above the ctl bits and results are steered back by that tag.
module secp256k1_mult_arb #(
   parameter int NUM_CLIENTS = 2,
   parameter int DAT_BITS    = 256,
   parameter int CTL_BITS    = 16,
   parameter int ID_BITS     = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic [NUM_CLIENTS*2*DAT_BITS-1:0]   i_req_dat,
   input  logic [NUM_CLIENTS*CTL_BITS-1:0]     i_req_ctl,
   input  logic [NUM_CLIENTS-1:0]              i_req_err,
   input  logic [NUM_CLIENTS-1:0]              i_req_val,
   output logic [NUM_CLIENTS-1:0]              o_req_rdy,
   output logic [2*DAT_BITS-1:0]               o_unit_dat,
   output logic [CTL_BITS+ID_BITS-1:0]         o_unit_ctl,
   output logic                                o_unit_err,
   output logic                                o_unit_val,
   input  logic                                i_unit_rdy,
   input  logic [DAT_BITS-1:0]                 i_unit_dat,
   input  logic [CTL_BITS+ID_BITS-1:0]         i_unit_ctl,
   input  logic                                i_unit_err,
   input  logic                                i_unit_val,
   output logic                                o_unit_rdy,
   output logic [NUM_CLIENTS*DAT_BITS-1:0]     o_res_dat,
   output logic [NUM_CLIENTS*CTL_BITS-1:0]     o_res_ctl,
   output logic [NUM_CLIENTS-1:0]              o_res_err,
   output logic [NUM_CLIENTS-1:0]              o_res_val,
   input  logic [NUM_CLIENTS-1:0]              i_res_rdy
);

   localparam logic [ID_BITS:0] NUM_TAGS = (ID_BITS+1)'(NUM_CLIENTS);

   logic [ID_BITS-1:0]    ptr;
   logic [ID_BITS-1:0]    hi_id, lo_id, grant_id, next_ptr;
   logic                  hi_any, lo_any, grant_any;
   logic                  unit_free;
   logic [2*DAT_BITS-1:0] sel_dat;
   logic [CTL_BITS-1:0]   sel_ctl;
   logic                  sel_err;

   logic                  res_full;
   logic [ID_BITS-1:0]    res_id;
   logic [DAT_BITS-1:0]   res_dat;
   logic [CTL_BITS-1:0]   res_ctl;
   logic                  res_err;
   logic                  res_rdy_sel;
   logic [ID_BITS-1:0]    ret_id;
   logic                  ret_bad;

   assign unit_free = !o_unit_val || i_unit_rdy;

   // Two-pass search: "hi" covers clients at or above ptr, "lo" is the wrapped remainder.
   always_comb begin
      hi_any = 1'b0;
      hi_id  = '0;
      lo_any = 1'b0;
      lo_id  = '0;
      for (int j = NUM_CLIENTS-1; j >= 0; j--) begin
         if (i_req_val[j]) begin
            lo_any = 1'b1;
            lo_id  = ID_BITS'(j);
            if (ID_BITS'(j) >= ptr) begin
               hi_any = 1'b1;
               hi_id  = ID_BITS'(j);
            end
         end
      end
      grant_any = hi_any || lo_any;
      grant_id  = hi_any ? hi_id : lo_id;
      next_ptr  = (grant_id == ID_BITS'(NUM_CLIENTS-1)) ? '0 : grant_id + ID_BITS'(1);
   end

   always_comb begin
      sel_dat   = '0;
      sel_ctl   = '0;
      sel_err   = 1'b0;
      o_req_rdy = '0;
      for (int j = 0; j < NUM_CLIENTS; j++) begin
         if (grant_id == ID_BITS'(j)) begin
            sel_dat = i_req_dat[j*2*DAT_BITS +: 2*DAT_BITS];
            sel_ctl = i_req_ctl[j*CTL_BITS +: CTL_BITS];
            sel_err = i_req_err[j];
            o_req_rdy[j] = !i_rst && unit_free && grant_any;
         end
      end
   end

   always_comb begin
      res_rdy_sel = 1'b0;
      o_res_val   = '0;
      for (int j = 0; j < NUM_CLIENTS; j++) begin
         if (res_id == ID_BITS'(j)) begin
            res_rdy_sel  = i_res_rdy[j];
            o_res_val[j] = res_full;
         end
      end
   end

   assign ret_id     = i_unit_ctl[CTL_BITS+ID_BITS-1:CTL_BITS];
   assign ret_bad    = ({1'b0, ret_id} >= NUM_TAGS);
   assign o_unit_rdy = !i_rst && (!res_full || res_rdy_sel);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr        <= '0;
         o_unit_dat <= '0;
         o_unit_ctl <= '0;
         o_unit_err <= 1'b0;
         o_unit_val <= 1'b0;
      end else if (unit_free) begin
         if (grant_any) begin
            o_unit_dat <= sel_dat;
            o_unit_ctl <= {grant_id, sel_ctl};
            o_unit_err <= sel_err;
            o_unit_val <= 1'b1;
            ptr        <= next_ptr;
         end else begin
            o_unit_val <= 1'b0;
         end
      end
   end

   // Capture takes priority over retire so a result can replace the one leaving in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         res_full <= 1'b0;
         res_id   <= '0;
         res_dat  <= '0;
         res_ctl  <= '0;
         res_err  <= 1'b0;
      end else if (i_unit_val && o_unit_rdy) begin
         res_full <= 1'b1;
         res_dat  <= i_unit_dat;
         res_ctl  <= i_unit_ctl[CTL_BITS-1:0];
         res_err  <= i_unit_err || ret_bad;
         res_id   <= ret_bad ? '0 : ret_id;
      end else if (res_full && res_rdy_sel) begin
         res_full <= 1'b0;
      end
   end

   assign o_res_dat = {NUM_CLIENTS{res_dat}};
   assign o_res_ctl = {NUM_CLIENTS{res_ctl}};
   assign o_res_err = {NUM_CLIENTS{res_err}};

endmodule
